// File: rtl/eth_bd_ram_arbiter_if.sv
// rtl/eth_bd_ram_arbiter_if.sv - host (bridge) and MAC descriptor access signals
interface eth_bd_ram_arbiter_if;
  logic        wb_psel_i;
  logic        wb_penable_i;
  logic        wb_pwrite_i;
  logic [31:0] wb_paddr_i;
  logic [31:0] wb_pwdata_i;
  logic [31:0] wb_prdata_o;
  logic        wb_BDAck_o;
  logic        mac_req_i;
  logic        mac_we_i;
  logic [7:0]  mac_addr_i;
  logic [31:0] mac_wdata_i;
  logic [31:0] mac_rdata_o;
  logic        mac_ack_o;

  modport slave (
    input  wb_psel_i, wb_penable_i, wb_pwrite_i, wb_paddr_i, wb_pwdata_i,
    output wb_prdata_o, wb_BDAck_o,
    input  mac_req_i, mac_we_i, mac_addr_i, mac_wdata_i,
    output mac_rdata_o, mac_ack_o
  );

  modport master (
    output wb_psel_i, wb_penable_i, wb_pwrite_i, wb_paddr_i, wb_pwdata_i,
    input  wb_prdata_o, wb_BDAck_o,
    output mac_req_i, mac_we_i, mac_addr_i, mac_wdata_i,
    input  mac_rdata_o, mac_ack_o
  );
endinterface

// File: rtl/eth_bd_ram_arbiter.sv
// rtl/eth_bd_ram_arbiter.sv - single-port descriptor RAM shared round-robin by host and MAC
module eth_bd_ram_arbiter #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input logic                  apb_pclk_i,
  input logic                  apb_presetn_i,
  eth_bd_ram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_ACK} state_t;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;      // 1 = MAC owns the current access
  logic            we_q, we_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            last_q, last_d;        // 1 = MAC was granted last
  logic            host_armed_q, host_armed_d;
  logic            mac_armed_q, mac_armed_d;
  logic            wb_ack_q, wb_ack_d;
  logic            mac_ack_q, mac_ack_d;
  logic [31:0]     wb_rdata_q, wb_rdata_d;
  logic [31:0]     mac_rdata_q, mac_rdata_d;

  logic [31:0]     mem [DEPTH];
  logic [31:0]     ram_rd;
  logic            host_req, mac_req, grant_mac;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^{bus.wb_paddr_i[31:AW+2], bus.wb_paddr_i[1:0]};
  assign ram_rd = mem[idx_q];

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    last_d       = last_q;
    wb_rdata_d   = wb_rdata_q;
    mac_rdata_d  = mac_rdata_q;
    wb_ack_d     = 1'b0;
    mac_ack_d    = 1'b0;
    grant_mac    = 1'b0;
    host_req     = bus.wb_psel_i & bus.wb_penable_i & host_armed_q;
    mac_req      = bus.mac_req_i & mac_armed_q;

    case (state_q)
      S_IDLE: begin
        if (host_req || mac_req) begin
          // On contention the side that did not win last time goes first.
          grant_mac = mac_req && (!host_req || !last_q);
          owner_d   = grant_mac;
          we_d      = grant_mac ? bus.mac_we_i    : bus.wb_pwrite_i;
          idx_d     = grant_mac ? bus.mac_addr_i  : bus.wb_paddr_i[AW+1:2];
          wdata_d   = grant_mac ? bus.mac_wdata_i : bus.wb_pwdata_i;
          last_d    = grant_mac;
          state_d   = S_ACC;
        end
      end
      S_ACC: begin
        state_d = S_ACK;
        if (owner_q) begin
          mac_ack_d = 1'b1;
          if (!we_q) mac_rdata_d = ram_rd;
        end else begin
          wb_ack_d = 1'b1;
          if (!we_q) wb_rdata_d = ram_rd;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A requester must drop its select after an ack before it can be served again.
    host_armed_d = host_armed_q;
    if (!bus.wb_psel_i)
      host_armed_d = 1'b1;
    else if (state_q == S_ACK && !owner_q)
      host_armed_d = 1'b0;

    mac_armed_d = mac_armed_q;
    if (!bus.mac_req_i)
      mac_armed_d = 1'b1;
    else if (state_q == S_ACK && owner_q)
      mac_armed_d = 1'b0;
  end

  always_ff @(posedge apb_pclk_i) begin
    if (!apb_presetn_i) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      last_q       <= 1'b1;
      host_armed_q <= 1'b1;
      mac_armed_q  <= 1'b1;
      wb_ack_q     <= 1'b0;
      mac_ack_q    <= 1'b0;
      wb_rdata_q   <= '0;
      mac_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      last_q       <= last_d;
      host_armed_q <= host_armed_d;
      mac_armed_q  <= mac_armed_d;
      wb_ack_q     <= wb_ack_d;
      mac_ack_q    <= mac_ack_d;
      wb_rdata_q   <= wb_rdata_d;
      mac_rdata_q  <= mac_rdata_d;
    end
  end

  // RAM contents survive reset; only a write landing on a reset edge is dropped.
  always_ff @(posedge apb_pclk_i) begin
    if (apb_presetn_i && state_q == S_ACC && we_q)
      mem[idx_q] <= wdata_q;
  end

  assign bus.wb_prdata_o = wb_rdata_q;
  assign bus.wb_BDAck_o  = wb_ack_q;
  assign bus.mac_rdata_o = mac_rdata_q;
  assign bus.mac_ack_o   = mac_ack_q;

endmodule
